// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default latencies. The pipeline decoder imports this same package.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;
  localparam int CNT_W               = 4;

  function automatic logic is_div_op(logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Operations that occupy the unit for several cycles.
  function automatic logic is_long_op(logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath working on the captured operands.
// Result packs {hi, lo}; div0 flags a divide whose divisor is zero.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic signed_ovf;

  // -2^31 / -1 cannot be represented; the quotient wraps to 0x80000000.
  assign signed_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    result = '0;
    div0   = 1'b0;
    case (op)
      OP_MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_MULTU: result = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        div0 = (b == 32'b0);
        if (signed_ovf) begin
          result = {32'h0, 32'h8000_0000};
        end else if (!div0) begin
          result = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
        end
      end
      OP_DIVU: begin
        div0 = (b == 32'b0);
        if (!div0) begin
          result = {a % b, a / b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: IDLE/RUN sequencing, latency counter,
// operand capture, HI/LO registers and the pipeline stall request.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       op_q, op_q_next;
  logic [31:0]      a_q, a_q_next;
  logic [31:0]      b_q, b_q_next;
  logic [31:0]      hi_q, hi_next;
  logic [31:0]      lo_q, lo_next;
  logic             done_q, done_next;
  logic [63:0]      result;
  logic             div0;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .div0   (div0)
  );

  // Priority: cancel, then counter expiry, then a new start from IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_q_next  = op_q;
    a_q_next   = a_q;
    b_q_next   = b_q;
    hi_next    = hi_q;
    lo_next    = lo_q;
    done_next  = 1'b0;

    if (cancel) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (state == ST_RUN) begin
      if (cnt == CNT_W'(1)) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        done_next  = 1'b1;
        if (!div0) begin
          hi_next = result[63:32];
          lo_next = result[31:0];
        end
      end else begin
        cnt_next = cnt - CNT_W'(1);
      end
    end else if (start) begin
      if (is_long_op(op)) begin
        state_next = ST_RUN;
        cnt_next   = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        op_q_next  = op;
        a_q_next   = a;
        b_q_next   = b;
      end else if (op == OP_MTHI) begin
        hi_next = a;
      end else if (op == OP_MTLO) begin
        lo_next = a;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      op_q   <= op_q_next;
      a_q    <= a_q_next;
      b_q    <= b_q_next;
      hi_q   <= hi_next;
      lo_q   <= lo_next;
      done_q <= done_next;
    end
  end

  assign busy  = (state == ST_RUN);
  assign stall = d_mdu_use && (busy || (start && is_long_op(op)));
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low (0 = reset).
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 SHALL have port op  input  4  operation code from the shared package: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
REQ-007 SHALL have port a  input  32  forwarded rs operand.
REQ-008 SHALL have port b  input  32  forwarded rt operand.
REQ-009 SHALL have port cancel  input  1  abort request (flush).
REQ-010 SHALL have port d_mdu_use  input  1  D-stage instruction is any MDU instruction (mult/div/mfhi/mflo/mthi/mtlo).
REQ-011 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-012 SHALL have port stall  output  1  freeze F/D and bubble E.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers.

Function
REQ-015 States SHALL be IDLE and RUN; a down-counter cnt SHALL be 4 bits wide, sized to cover max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE, a start with op in {MULT, MULTU, DIV, DIVU} and cancel=0 SHALL capture op/a/b, load cnt with the op's latency, and enter RUN.
REQ-017 busy SHALL be 1 for exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES), and 0 otherwise.
REQ-018 On the edge where cnt==1 in RUN, the block SHALL write hi/lo, return to IDLE and assert done for the following cycle only.
REQ-019 MULT/MULTU SHALL give the signed/unsigned 64-bit product: HI = [63:32], LO = [31:0].
REQ-020 DIV/DIVU SHALL give LO = quotient truncated toward zero and HI = remainder with the dividend's sign (signed case).
REQ-021 Divide by zero SHALL leave hi/lo unchanged; busy timing and the done pulse are unaffected.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write a to hi/lo at that edge, with no busy and no done.
REQ-023 A start received while in RUN SHALL be ignored (protocol error: the pipeline guarantees it never occurs).
REQ-024 op=NOP or an undefined code SHALL have no effect.
REQ-025 stall SHALL equal d_mdu_use AND (busy OR (start AND op is MULT/MULTU/DIV/DIVU)), and SHALL be combinational.
REQ-026 cancel SHALL have priority over start: start is ignored in the same cycle.
REQ-027 cancel in RUN SHALL return to IDLE at the next edge, with hi/lo holding their pre-operation values and no done pulse.
REQ-028 Results SHALL be computed from the captured operands; a and b may change after the start edge.

Reset
REQ-029 While reset=0, the block SHALL immediately hold state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0 and the captured operands at 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no result write or done SHALL follow deassertion.
REQ-031 Priority SHALL be reset > cancel > cnt expiry > start.

Structure
REQ-032 Package mdu_pkg SHALL hold the op codes, the state enum and the default latency constants; the pipeline decoder SHALL share it.
REQ-033 A combinational sub-module mdu_arith (inputs: captured op, a, b; outputs: 64-bit result and div0 flag) SHALL hold the arithmetic; mdu_ctrl SHALL hold the FSM, counter and registers.

Verification
REQ-034 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-035 DIVU a=7, b=2 -> busy 10 cycles, then lo=3, hi=1; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIV b=0 with hi=0x11, lo=0x22 -> 10 busy cycles, done pulses, hi=0x11, lo=0x22 unchanged.
REQ-037 MULT started, d_mdu_use=1 (mflo in D) -> stall=1 in the start cycle and every busy cycle, 0 in the cycle busy falls.
REQ-038 MULT started, cancel at cycle 3 -> busy=0 next cycle, no done, hi/lo unchanged; reset=0 mid-DIV -> all outputs 0 immediately, with no later write.
REQ-039 MTHI a=0xABCD -> hi=0xABCD at the next edge, busy stays 0, done stays 0.
